// File: rtl/stack_controller_pkg.sv
// rtl/stack_controller_pkg.sv - shared memory-mode, opcode and FSM state constants for the stack controller
package stack_controller_pkg;

  localparam int MEMORY_ADDR_BITS = 3;
  localparam int DATA_BITS        = 4;

  localparam logic [1:0] MEMORY_MODE_IDLE  = 2'd0;
  localparam logic [1:0] MEMORY_MODE_CLEAR = 2'd1;
  localparam logic [1:0] MEMORY_MODE_READ  = 2'd2;
  localparam logic [1:0] MEMORY_MODE_WRITE = 2'd3;

  localparam logic [1:0] OP_PUSH  = 2'd0;
  localparam logic [1:0] OP_POP   = 2'd1;
  localparam logic [1:0] OP_PEEK  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_CLR   = 3'd4;

endpackage

// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - LIFO controller driving an external 1-cycle-latency memory
// Optional PEEK support is enabled by defining STACK_CTRL_PEEK_EN.
module stack_controller
  import stack_controller_pkg::*;
#(
  parameter int ADDR_BITS = MEMORY_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  input  logic [DATA_BITS-1:0] cmd_data,
  output logic                 cmd_ready,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 rsp_error,
  output logic [ADDR_BITS:0]   depth,
  output logic                 full,
  output logic                 empty,
  output logic [1:0]           mem_mode,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic [DATA_BITS-1:0] mem_data_in,
  input  logic [DATA_BITS-1:0] mem_data_out
);

  localparam logic [ADDR_BITS:0]   SP_FULL  = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]   SP_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic [2:0]           state;
  logic [ADDR_BITS:0]   sp;
  logic [1:0]           op_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 err_q;

  assign depth     = sp;
  assign full      = (sp == SP_FULL);
  assign empty     = (sp == '0);
  assign cmd_ready = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      sp     <= '0;
      op_q   <= OP_PUSH;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            err_q  <= 1'b0;
            // Rejected commands go straight to RESP so they answer at N+1 without touching memory.
            case (cmd_op)
              OP_PUSH: begin
                if (full) begin
                  err_q <= 1'b1;
                  state <= ST_RESP;
                end else begin
                  state <= ST_WRITE;
                end
              end
              OP_POP: begin
                if (empty) begin
                  err_q <= 1'b1;
                  state <= ST_RESP;
                end else begin
                  state <= ST_READ;
                end
              end
              OP_PEEK: begin
`ifdef STACK_CTRL_PEEK_EN
                if (empty) begin
                  err_q <= 1'b1;
                  state <= ST_RESP;
                end else begin
                  state <= ST_READ;
                end
`else
                err_q <= 1'b1;
                state <= ST_RESP;
`endif
              end
              default: state <= ST_CLR;
            endcase
          end
        end
        ST_WRITE: begin
          sp    <= sp + SP_ONE;
          state <= ST_IDLE;
        end
        ST_READ: state <= ST_RESP;
        ST_RESP: begin
          if (!err_q && op_q == OP_POP) sp <= sp - SP_ONE;
          state <= ST_IDLE;
        end
        ST_CLR: begin
          sp    <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rsp_valid   = 1'b0;
    rsp_error   = 1'b0;
    rsp_data    = '0;
    mem_mode    = MEMORY_MODE_IDLE;
    mem_address = '0;
    mem_data_in = '0;
    case (state)
      ST_WRITE: begin
        rsp_valid   = 1'b1;
        mem_mode    = MEMORY_MODE_WRITE;
        mem_address = sp[ADDR_BITS-1:0];
        mem_data_in = data_q;
      end
      ST_READ: begin
        mem_mode    = MEMORY_MODE_READ;
        mem_address = sp[ADDR_BITS-1:0] - ADDR_ONE;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_error = err_q;
        rsp_data  = err_q ? '0 : mem_data_out;
      end
      ST_CLR: begin
        rsp_valid = 1'b1;
        mem_mode  = MEMORY_MODE_CLEAR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_controller.sv
// tb/tb_stack_controller.sv - scoreboard bench for stack_controller with a behavioural 1-cycle memory
module tb_stack_controller;
  import stack_controller_pkg::*;

  localparam int AB  = MEMORY_ADDR_BITS;
  localparam int CAP = 1 << AB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic [3:0]    cmd_data = 4'd0;
  logic          cmd_ready, rsp_valid, rsp_error, full, empty;
  logic [3:0]    rsp_data, mem_data_in;
  logic [3:0]    mem_data_out = 4'd0;
  logic [AB:0]   depth;
  logic [1:0]    mem_mode;
  logic [AB-1:0] mem_address;

  always #5 clk = ~clk;

  stack_controller #(.ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .depth(depth), .full(full), .empty(empty), .mem_mode(mem_mode), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  logic [3:0] mem [CAP];
  always @(posedge clk) begin
    case (mem_mode)
      MEMORY_MODE_WRITE: mem[mem_address] <= mem_data_in;
      MEMORY_MODE_READ:  mem_data_out <= mem[mem_address];
      MEMORY_MODE_CLEAR: for (int i = 0; i < CAP; i++) mem[i] <= 4'd0;
      default: ;
    endcase
  end

  typedef struct {
    logic       err;
    logic [3:0] data;
    int         cyc;
  } rsp_t;

  rsp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_wr = 0;
  int n_clr = 0;
  logic [1:0]    last_mode;
  logic [AB-1:0] last_addr;
  logic [3:0]    mstk [CAP];
  int mdepth = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_mode == MEMORY_MODE_WRITE) n_wr++;
    if (mem_mode == MEMORY_MODE_CLEAR) n_clr++;
  end

  rsp_t got_e;
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        got_e = sb.pop_front();
        check("rsp_error", 32'(rsp_error), 32'(got_e.err));
        check("rsp_data", 32'(rsp_data), 32'(got_e.data));
        check("rsp_cycle", cyc, got_e.cyc);
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Drives one command at a negedge; the model decides the response and its cycle.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] d, input bit hold = 1'b0);
    rsp_t e;
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    e.cyc  = cyc + 1;
    e.err  = 1'b0;
    e.data = 4'd0;
    case (op)
      OP_PUSH: begin
        if (mdepth == CAP) e.err = 1'b1;
        else begin
          mstk[mdepth] = d;
          mdepth++;
        end
      end
      OP_POP: begin
        if (mdepth == 0) e.err = 1'b1;
        else begin
          mdepth--;
          e.data = mstk[mdepth];
          e.cyc  = cyc + 2;
        end
      end
      OP_PEEK: begin
`ifdef STACK_CTRL_PEEK_EN
        if (mdepth == 0) e.err = 1'b1;
        else begin
          e.data = mstk[mdepth-1];
          e.cyc  = cyc + 2;
        end
`else
        e.err = 1'b1;
`endif
      end
      default: mdepth = 0;
    endcase
    sb.push_back(e);
    @(negedge clk);
    last_mode = mem_mode;
    last_addr = mem_address;
    if (hold) begin
      cmd_op   = OP_PUSH;
      cmd_data = 4'hF;
      wait_ready();
    end
    cmd_valid = 1'b0;
  endtask

  int wr0, clr0;
  logic [3:0] v;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_mem_mode", 32'(mem_mode), 32'(MEMORY_MODE_IDLE));
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst = 1'b0;

    do_cmd(OP_POP, 4'd0);
    check("underflow_mode", 32'(last_mode), 32'(MEMORY_MODE_IDLE));
    wait_ready();
    check("underflow_empty", 32'(empty), 32'd1);

    do_cmd(OP_PUSH, 4'hA);
    do_cmd(OP_PUSH, 4'h5);
    do_cmd(OP_PUSH, 4'h3);
    wait_ready();
    check("push3_depth", 32'(depth), 32'd3);
    check("mem0", 32'(mem[0]), 32'hA);
    check("mem1", 32'(mem[1]), 32'h5);
    check("mem2", 32'(mem[2]), 32'h3);

    do_cmd(OP_POP, 4'd0);
    check("pop_mode", 32'(last_mode), 32'(MEMORY_MODE_READ));
    check("pop_addr", 32'(last_addr), 32'd2);
    wait_ready();
    check("pop_depth", 32'(depth), 32'd2);

    do_cmd(OP_PEEK, 4'd0);
`ifdef STACK_CTRL_PEEK_EN
    check("peek_mode", 32'(last_mode), 32'(MEMORY_MODE_READ));
`else
    check("peek_mode", 32'(last_mode), 32'(MEMORY_MODE_IDLE));
`endif
    wait_ready();
    check("peek_depth", 32'(depth), 32'd2);

    clr0 = n_clr;
    do_cmd(OP_CLEAR, 4'd0);
    wait_ready();
    check("clear_cycles", n_clr - clr0, 32'd1);
    check("clear_depth", 32'(depth), 32'd0);

    for (int i = 0; i < CAP; i++) begin
      v = 4'($urandom_range(15, 0));
      do_cmd(OP_PUSH, v);
    end
    wait_ready();
    check("full_flag", 32'(full), 32'd1);
    check("full_depth", 32'(depth), 32'(CAP));
    wr0 = n_wr;
    do_cmd(OP_PUSH, 4'h9);
    wait_ready();
    check("overflow_no_write", n_wr - wr0, 32'd0);
    check("overflow_full", 32'(full), 32'd1);
    for (int i = 0; i < CAP; i++) do_cmd(OP_POP, 4'd0);
    wait_ready();
    check("drain_empty", 32'(empty), 32'd1);

    for (int i = 0; i < 4; i++) do_cmd(OP_PUSH, 4'(i + 1));
    do_cmd(OP_CLEAR, 4'd0);
    wait_ready();
    check("clear4_depth", 32'(depth), 32'd0);
    do_cmd(OP_PUSH, 4'h7);
    do_cmd(OP_POP, 4'd0);

    do_cmd(OP_PUSH, 4'hC);
    do_cmd(OP_PUSH, 4'hD);
    do_cmd(OP_POP, 4'd0, 1'b1);
    wait_ready();
    check("hold_depth", 32'(depth), 32'(mdepth));

    // Reset lands while a POP sits in READ; the POP must vanish without a response.
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = OP_POP;
    @(negedge clk);
    check("rst_mid_read", 32'(mem_mode), 32'(MEMORY_MODE_READ));
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdepth = 0;
    check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    check("rst_mid_ready", 32'(cmd_ready), 32'd1);
    check("rst_mid_depth", 32'(depth), 32'd0);
    @(negedge clk);
    check("rst_mid_quiet", 32'(rsp_valid), 32'd0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
